// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: wormhole round-robin arbiter for one router output port.
// A head flit wins the channel and keeps it until that requester's tail flit
// has been accepted. Accepted flits land in a one-entry output register.
// Optional feature macro: NOC_ARB_ERR_CNT_EN adds err_cnt, a saturating count
// of IDLE cycles in which some requester offers a flit without HEAD set.
module noc_output_arbiter #(
  parameter int FLIT_WIDTH = 64,
  parameter int PORTS      = 5,
  parameter int IDW        = $clog2(PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PORTS-1:0][FLIT_WIDTH-1:0] req_flit,
  input  logic [PORTS-1:0]                 req_valid,
  output logic [PORTS-1:0]                 req_ready,
  output logic [FLIT_WIDTH-1:0]            out_flit,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [IDW-1:0]                   grant_id,
  output logic                             busy
`ifdef NOC_ARB_ERR_CNT_EN
  ,
  output logic [15:0]                      err_cnt
`endif
);

  localparam int HEAD = FLIT_WIDTH - 1;
  localparam int TAIL = FLIT_WIDTH - 2;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state, state_nxt;
  logic [IDW-1:0]          ptr, ptr_nxt;
  logic [IDW-1:0]          owner, owner_nxt;
  logic [IDW-1:0]          grant, grant_nxt;

  logic [PORTS-1:0]        head;
  logic [PORTS-1:0]        eligible;
  logic [IDW-1:0]          win;
  logic                    win_found;
  logic [IDW-1:0]          sel;
  logic                    sel_ok;
  logic                    can_accept;
  logic                    xfer;
  logic [FLIT_WIDTH-1:0]   sel_flit;
  logic                    sel_tail;

  // Output register stage (p1): one flit buffered toward the link.
  logic [FLIT_WIDTH-1:0]   flit_p1;
  logic                    vld_p1;

  assign can_accept = !vld_p1 || out_ready;

  // Extract HEAD bits; only valid heads may compete in IDLE.
  always_comb begin
    head = '0;
    for (int i = 0; i < PORTS; i++) begin
      head[i] = req_flit[i][HEAD];
    end
    eligible = req_valid & head;
  end

  // Round-robin scan starting just after the last packet's owner.
  always_comb begin
    logic [IDW-1:0] cand;
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= PORTS; k++) begin
      cand = IDW'((int'(ptr) + k) % PORTS);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  // Steer ready to the winner (IDLE) or the locked owner; HEAD ignored while locked.
  always_comb begin
    req_ready = '0;
    sel       = (state == LOCKED) ? owner : win;
    sel_ok    = (state == LOCKED) ? 1'b1  : win_found;
    if (sel_ok && can_accept) begin
      req_ready[sel] = 1'b1;
    end
    xfer     = |(req_valid & req_ready);
    sel_flit = req_flit[sel];
    sel_tail = sel_flit[TAIL];
  end

  // Next-state logic for the lock FSM, round-robin pointer and grant record.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (xfer) begin
          grant_nxt = sel;
          if (sel_tail) begin
            ptr_nxt = sel;
          end else begin
            state_nxt = LOCKED;
            owner_nxt = sel;
          end
        end
      end
      LOCKED: begin
        if (xfer && sel_tail) begin
          state_nxt = IDLE;
          ptr_nxt   = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state registers; ptr resets to PORTS-1 so port 0 is scanned first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= IDW'(PORTS - 1);
      owner <= '0;
      grant <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      grant <= grant_nxt;
    end
  end

  // Output register: load on any accept, drain when downstream takes the flit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      flit_p1 <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      flit_p1 <= sel_flit;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_flit  = flit_p1;
  assign out_valid = vld_p1;
  assign grant_id  = grant;
  assign busy      = (state == LOCKED);

`ifdef NOC_ARB_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic        err_event;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign err_event = (state == IDLE) && |(req_valid & ~head);

  // Count IDLE cycles with a stray body/tail flit on any requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_event) begin
      err_cnt_q <= sat_inc16(err_cnt_q);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
